chip8_rand_byte_server: RTL and testbench

CHIP8_RAND_BYTE_SERVER -- requirements
Module: chip8_rand_byte_server

---
 rtl/chip8_rand_byte_server.sv | 132 +++++++++++++
 tb/tb_chip8_rand_byte_server.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_rand_byte_server.sv
// Buffers XOR-folded samples of a free-running generator and serves masked random bytes
// to the CPU (CXNN). It also flags a generator that stops producing fresh values.
module chip8_rand_byte_server #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                          cpu_clk,
  input  logic                          reset_n,
  input  logic [15:0]                   rand_num,
  input  logic                          req,
  input  logic [7:0]                    mask,
  output logic [7:0]                    rand_byte,
  output logic                          rand_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          gen_stuck
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [15:0]         prev_q, prev_d;
  logic [7:0]          mask_q, mask_d;
  logic [7:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic [StallW-1:0]   stall_q, stall_d;

  logic                full;
  logic                push;
  logic                pop;
  logic [7:0]          out_mask;
  logic [7:0]          push_byte;

  // Capture decisions use the pre-pop count, so a pop never frees a slot on the same edge.
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign push      = (rand_num != 16'h0000) && (rand_num != prev_q) && !full;
  assign push_byte = rand_num[15:8] ^ rand_num[7:0];

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pop      = 1'b0;
    out_mask = mask;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (count_q != '0) begin
            pop      = 1'b1;
            out_mask = mask;
          end else begin
            mask_d  = mask;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          out_mask = mask_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    prev_d   = push ? rand_num : prev_q;
    byte_d   = pop  ? (mem_q[rd_ptr_q] & out_mask) : byte_q;
    valid_d  = pop;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    stall_d = stall_q;
    if (push) begin
      stall_d = '0;
    end else if (!full && (stall_q != StallW'(STALL_LIMIT))) begin
      stall_d = stall_q + StallW'(1);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says they were written.
  always_ff @(posedge cpu_clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  assign rand_byte  = byte_q;
  assign rand_valid = valid_q;
  assign busy       = (state_q == StWait);
  assign fifo_count = count_q;
  assign gen_stuck  = (stall_q == StallW'(STALL_LIMIT));

endmodule

// File: tb/tb_chip8_rand_byte_server.sv
// Self-checking bench for chip8_rand_byte_server: a vector table plus directed corner cases,
// with returned bytes matched against a queue of expected values.
module tb_chip8_rand_byte_server;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rand_num = 16'h0000;
  logic        req = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic [7:0]  rand_byte;
  logic        rand_valid;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        gen_stuck;

  chip8_rand_byte_server #(
    .FIFO_DEPTH (4),
    .STALL_LIMIT(255)
  ) dut (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .rand_num  (rand_num),
    .req       (req),
    .mask      (mask),
    .rand_byte (rand_byte),
    .rand_valid(rand_valid),
    .busy      (busy),
    .fifo_count(fifo_count),
    .gen_stuck (gen_stuck)
  );

  always #5 cpu_clk = ~cpu_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [15:0] rn;
    logic        rq;
    logic [7:0]  mk;
    logic [2:0]  cnt;
    logic        bsy;
    logic        vld;
    logic [7:0]  byt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] rn);
    reset_n  = 1'b0;
    rand_num = rn;
    req      = 1'b0;
    mask     = 8'h00;
    tick();
    sb_q.delete();
    reset_n = 1'b1;
  endtask

  // Every returned byte must match the oldest outstanding expectation.
  always @(negedge cpu_clk) begin
    if (rand_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: rand_valid with byte 0x%0h, expected none", rand_byte);
      end else begin
        check("sb_byte", {24'h0, rand_byte}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    //          rn        rq    mk     cnt   bsy   vld   byte
    vecs[0]  = '{16'h0001, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{16'h0002, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{16'h0003, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{16'h0004, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{16'h0005, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{16'h0004, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{16'h0004, 1'b1, 8'hFF, 3'd2, 1'b0, 1'b1, 8'h02};
    vecs[7]  = '{16'h0004, 1'b1, 8'hFE, 3'd1, 1'b0, 1'b1, 8'h02};
    vecs[8]  = '{16'h0004, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 8'h04};
    vecs[9]  = '{16'h0004, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{16'h0004, 1'b1, 8'h3C, 3'd0, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{16'h0004, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{16'hABCD, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{16'hABCD, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h24};
    vecs[14] = '{16'h0102, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00};
    vecs[15] = '{16'h0204, 1'b1, 8'hFF, 3'd1, 1'b0, 1'b1, 8'h03};
    vecs[16] = '{16'h0204, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 8'h06};
    vecs[17] = '{16'h0204, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};

    // Reset state, then first capture and a masked 1-cycle-latency pop.
    do_reset(16'hF5D2);
    reset_n = 1'b0;
    check("rst_count", {29'h0, fifo_count}, 32'd0);
    check("rst_valid", {31'h0, rand_valid}, 32'd0);
    check("rst_byte", {24'h0, rand_byte}, 32'h00);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_stuck", {31'h0, gen_stuck}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("cap_count", {29'h0, fifo_count}, 32'd1);
    req  = 1'b1;
    mask = 8'h0F;
    sb_q.push_back(8'h07);
    tick();
    check("pop_valid", {31'h0, rand_valid}, 32'd1);
    check("pop_byte", {24'h0, rand_byte}, 32'h07);
    check("pop_count", {29'h0, fifo_count}, 32'd0);
    req = 1'b0;
    tick();
    check("hold_valid", {31'h0, rand_valid}, 32'd0);
    check("hold_byte", {24'h0, rand_byte}, 32'h07);

    // Request on an empty FIFO waits for the next capture.
    do_reset(16'h0000);
    req  = 1'b1;
    mask = 8'hFF;
    tick();
    check("wait_busy", {31'h0, busy}, 32'd1);
    check("wait_valid", {31'h0, rand_valid}, 32'd0);
    req      = 1'b0;
    mask     = 8'h00;
    rand_num = 16'h1234;
    tick();
    check("wait_push_count", {29'h0, fifo_count}, 32'd1);
    check("wait_nobypass", {31'h0, rand_valid}, 32'd0);
    sb_q.push_back(8'h26);
    tick();
    check("wait_valid2", {31'h0, rand_valid}, 32'd1);
    check("wait_byte", {24'h0, rand_byte}, 32'h26);
    check("wait_busy2", {31'h0, busy}, 32'd0);
    check("wait_count2", {29'h0, fifo_count}, 32'd0);

    // Vector table: fill to full, drop, back-to-back pops, WAIT with latched mask, push+pop.
    do_reset(16'h0000);
    for (int i = 0; i < 18; i++) begin
      rand_num = vecs[i].rn;
      req      = vecs[i].rq;
      mask     = vecs[i].mk;
      if (vecs[i].vld) sb_q.push_back(vecs[i].byt);
      tick();
      check($sformatf("v%0d_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].cnt});
      check($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].bsy});
      check($sformatf("v%0d_valid", i), {31'h0, rand_valid}, {31'h0, vecs[i].vld});
    end

    // Full FIFO with a new value and a request on the same edge: pop only.
    do_reset(16'h0000);
    for (int i = 1; i <= 4; i++) begin
      rand_num = 16'(i);
      tick();
    end
    check("full_count", {29'h0, fifo_count}, 32'd4);
    rand_num = 16'h0009;
    req      = 1'b1;
    mask     = 8'hFF;
    sb_q.push_back(8'h01);
    tick();
    check("full_pop_count", {29'h0, fifo_count}, 32'd3);
    check("full_pop_valid", {31'h0, rand_valid}, 32'd1);
    req = 1'b0;
    tick();
    check("refill_count", {29'h0, fifo_count}, 32'd4);
    repeat (300) tick();
    check("full_no_stuck", {31'h0, gen_stuck}, 32'd0);
    check("full_hold_count", {29'h0, fifo_count}, 32'd4);

    // Stall detector saturates at the limit and clears on the next capture.
    do_reset(16'h0100);
    tick();
    check("stall_cap", {29'h0, fifo_count}, 32'd1);
    repeat (254) tick();
    check("stall_254", {31'h0, gen_stuck}, 32'd0);
    tick();
    check("stall_255", {31'h0, gen_stuck}, 32'd1);
    tick();
    check("stall_sat", {31'h0, gen_stuck}, 32'd1);
    rand_num = 16'h0200;
    tick();
    check("stall_clear", {31'h0, gen_stuck}, 32'd0);
    check("stall_count", {29'h0, fifo_count}, 32'd2);

    // Reset during WAIT discards the pending request.
    do_reset(16'h0000);
    req  = 1'b1;
    mask = 8'hFF;
    tick();
    check("rw_busy", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    req     = 1'b0;
    tick();
    check("rw_rst_busy", {31'h0, busy}, 32'd0);
    reset_n  = 1'b1;
    rand_num = 16'h1234;
    tick();
    check("rw_count", {29'h0, fifo_count}, 32'd1);
    check("rw_busy2", {31'h0, busy}, 32'd0);
    check("rw_valid", {31'h0, rand_valid}, 32'd0);
    tick();
    check("rw_valid2", {31'h0, rand_valid}, 32'd0);
    check("rw_count2", {29'h0, fifo_count}, 32'd1);

    tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
